// File: rtl/inst_fetch_prefetch.sv
// inst_fetch_prefetch: RV32I instruction fetch with AXI4 INCR burst prefetch FIFO
//
// Bursts of up to BURST_LEN words are issued only when the FIFO has room for a
// full burst, so R beats are never back-pressured. A redirect flushes the FIFO
// and any in-flight burst is drained and dropped before the next AR goes out.
//
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_exec                 run enable (no new AR while low)
//   i_stall                pipeline cannot take o_inst this cycle
//   i_redirect/_pc         one-cycle flush and restart at i_redirect_pc (word aligned)
//   o_pc                   PC of the instruction presented on o_inst
//   o_inst_valid, o_inst   instruction at the FIFO head
//   o_mem_wait             running with an empty FIFO
//   o_fetch_err            sticky error from a kept beat with RRESP != OKAY
//   o_m_axi_ar*/i_m_axi_arready    AXI4 read address channel
//   i_m_axi_r*/o_m_axi_rready      AXI4 read data channel
module inst_fetch_prefetch #(
    parameter int C_M_AXI_THREAD_ID_WIDTH = 1,
    parameter int C_M_AXI_ADDR_WIDTH      = 32,
    parameter int C_M_AXI_DATA_WIDTH      = 32,
    parameter int C_M_AXI_ARUSER_WIDTH    = 1,
    parameter int C_M_AXI_RUSER_WIDTH     = 4,
    parameter int BURST_LEN               = 4,
    parameter int FIFO_DEPTH              = 8,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_exec,
    input  logic                               i_stall,
    input  logic                               i_redirect,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]      i_redirect_pc,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]      o_pc,
    output logic                               o_inst_valid,
    output logic [C_M_AXI_DATA_WIDTH-1:0]      o_inst,
    output logic                               o_mem_wait,
    output logic                               o_fetch_err,
    output logic [C_M_AXI_THREAD_ID_WIDTH-1:0] o_m_axi_arid,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]      o_m_axi_araddr,
    output logic [7:0]                         o_m_axi_arlen,
    output logic [2:0]                         o_m_axi_arsize,
    output logic [1:0]                         o_m_axi_arburst,
    output logic                               o_m_axi_arlock,
    output logic [3:0]                         o_m_axi_arcache,
    output logic [2:0]                         o_m_axi_arprot,
    output logic [3:0]                         o_m_axi_arqos,
    output logic [C_M_AXI_ARUSER_WIDTH-1:0]    o_m_axi_aruser,
    output logic                               o_m_axi_arvalid,
    input  logic                               i_m_axi_arready,
    input  logic [C_M_AXI_THREAD_ID_WIDTH-1:0] i_m_axi_rid,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]      i_m_axi_rdata,
    input  logic [1:0]                         i_m_axi_rresp,
    input  logic                               i_m_axi_rlast,
    input  logic [C_M_AXI_RUSER_WIDTH-1:0]     i_m_axi_ruser,
    input  logic                               i_m_axi_rvalid,
    output logic                               o_m_axi_rready
);
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0]    r_state;
    logic [AW-1:0] r_fetch_addr;
    logic [AW-1:0] r_deliver_pc;
    logic [AW-1:0] r_araddr;
    logic [7:0]    r_arlen;
    logic          r_discard;
    logic          r_fetch_err;
    logic [PW:0]   r_wr;
    logic [PW:0]   r_rd;
    logic [DW-1:0] r_mem [FIFO_DEPTH];

    logic [PW:0]   w_count;
    logic          w_empty;
    logic          w_room;
    logic [4:0]    w_off;
    logic [4:0]    w_beats;
    logic          w_start;
    logic          w_beat;
    logic          w_last;
    logic          w_push;
    logic          w_pop;
    logic [AW-1:0] w_redirect_pc;
    logic          w_unused;

    assign w_count       = r_wr - r_rd;
    assign w_empty       = r_wr == r_rd;
    assign w_room        = int'(w_count) + BURST_LEN <= FIFO_DEPTH;
    // Start mid-block so the burst ends on a 4*BURST_LEN-byte boundary.
    assign w_off         = 5'((r_fetch_addr >> 2) & AW'(BURST_LEN - 1));
    assign w_beats       = 5'(BURST_LEN) - w_off;
    assign w_start       = r_state == S_IDLE && i_exec && !i_redirect && w_room;
    assign w_beat        = r_state == S_DATA && i_m_axi_rvalid;
    assign w_last        = w_beat && i_m_axi_rlast;
    assign w_push        = w_beat && !r_discard && !i_redirect;
    assign w_pop         = o_inst_valid && !i_stall && !i_redirect;
    assign w_redirect_pc = {i_redirect_pc[AW-1:2], 2'b00};
    assign w_unused      = ^{i_m_axi_rid, i_m_axi_ruser, i_redirect_pc[1:0]};

    assign o_pc            = r_deliver_pc;
    assign o_inst_valid    = i_exec && !w_empty;
    assign o_inst          = w_empty ? '0 : r_mem[r_rd[PW-1:0]];
    assign o_mem_wait      = i_exec && w_empty;
    assign o_fetch_err     = r_fetch_err;
    assign o_m_axi_arid    = '0;
    assign o_m_axi_araddr  = r_araddr;
    assign o_m_axi_arlen   = r_arlen;
    assign o_m_axi_arsize  = 3'b010;
    assign o_m_axi_arburst = 2'b01;
    assign o_m_axi_arlock  = 1'b0;
    assign o_m_axi_arcache = 4'b0011;
    assign o_m_axi_arprot  = 3'b000;
    assign o_m_axi_arqos   = 4'b0000;
    assign o_m_axi_aruser  = '0;
    assign o_m_axi_arvalid = r_state == S_REQ;
    assign o_m_axi_rready  = r_state == S_DATA;

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr[PW-1:0]] <= i_m_axi_rdata;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_fetch_addr <= RESET_PC;
            r_deliver_pc <= RESET_PC;
            r_araddr     <= '0;
            r_arlen      <= '0;
            r_discard    <= 1'b0;
            r_fetch_err  <= 1'b0;
            r_wr         <= '0;
            r_rd         <= '0;
        end else begin
            if (w_start) begin
                r_state  <= S_REQ;
                r_araddr <= r_fetch_addr;
                r_arlen  <= 8'(w_beats - 5'd1);
            end
            if (r_state == S_REQ && i_m_axi_arready) r_state <= S_DATA;
            if (w_last) begin
                r_state   <= S_IDLE;
                r_discard <= 1'b0;
                if (!r_discard) r_fetch_addr <= r_fetch_addr + ((AW'(r_arlen) + AW'(1)) << 2);
            end
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) begin
                r_rd         <= r_rd + 1'b1;
                r_deliver_pc <= r_deliver_pc + AW'(4);
            end
            if (w_push && i_m_axi_rresp != 2'b00) r_fetch_err <= 1'b1;
            // Redirect overrides everything above; a redirect on the RLAST beat
            // has nothing left to drain, so discard is not armed then.
            if (i_redirect) begin
                r_wr         <= '0;
                r_rd         <= '0;
                r_deliver_pc <= w_redirect_pc;
                r_fetch_addr <= w_redirect_pc;
                if (r_state != S_IDLE && !w_last) r_discard <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch_prefetch.sv
// tb_inst_fetch_prefetch: directed bench for inst_fetch_prefetch with a 1-cycle-latency AXI slave
module tb_inst_fetch_prefetch;
    logic        clk = 0;
    logic        rst = 1;
    logic        exec = 0;
    logic        stall = 0;
    logic        redirect = 0;
    logic [31:0] redirect_pc = 0;
    logic [31:0] pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic        mem_wait;
    logic        fetch_err;
    logic [0:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic [3:0]  arqos;
    logic [0:0]  aruser;
    logic        arvalid;
    logic        rready;

    logic        ar_block = 0;
    logic [31:0] err_addr = 32'h1;
    logic        s_rvalid;
    logic [31:0] s_addr;
    int          s_left;
    int          ar_count;
    int          n_checks = 0;
    int          n_err = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    inst_fetch_prefetch dut (
        .i_clk(clk), .i_rst(rst), .i_exec(exec), .i_stall(stall),
        .i_redirect(redirect), .i_redirect_pc(redirect_pc),
        .o_pc(pc), .o_inst_valid(inst_valid), .o_inst(inst),
        .o_mem_wait(mem_wait), .o_fetch_err(fetch_err),
        .o_m_axi_arid(arid), .o_m_axi_araddr(araddr), .o_m_axi_arlen(arlen),
        .o_m_axi_arsize(arsize), .o_m_axi_arburst(arburst), .o_m_axi_arlock(arlock),
        .o_m_axi_arcache(arcache), .o_m_axi_arprot(arprot), .o_m_axi_arqos(arqos),
        .o_m_axi_aruser(aruser), .o_m_axi_arvalid(arvalid), .i_m_axi_arready(!ar_block),
        .i_m_axi_rid(1'b0), .i_m_axi_rdata(mem_word(s_addr)),
        .i_m_axi_rresp(s_addr == err_addr ? 2'b10 : 2'b00),
        .i_m_axi_rlast(s_left == 1), .i_m_axi_ruser(4'h0),
        .i_m_axi_rvalid(s_rvalid), .o_m_axi_rready(rready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) begin
            s_rvalid <= 0;
            s_left   <= 0;
            s_addr   <= 0;
            ar_count <= 0;
        end else if (arvalid && !ar_block) begin
            s_addr   <= araddr;
            s_left   <= int'(arlen) + 1;
            ar_count <= ar_count + 1;
        end else if (s_left != 0) begin
            if (!s_rvalid) s_rvalid <= 1;
            else if (rready) begin
                if (s_left == 1) s_rvalid <= 0;
                s_left <= s_left - 1;
                s_addr <= s_addr + 4;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit cond(input int sel);
        case (sel)
            0: return inst_valid;
            1: return arvalid;
            2: return s_rvalid && s_addr == 32'h8;
            default: return s_rvalid;
        endcase
    endfunction

    task automatic wait_sel(input string tag, input int sel);
        int n = 0;
        while (!cond(sel) && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 32'(cond(sel)), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1; exec = 0; stall = 0; redirect = 0; ar_block = 0;
        repeat (2) tick();
        rst = 0;
    endtask

    initial begin
        // 1: reset state, first two bursts, in-order delivery
        do_reset();
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst", inst, 0);
        chk("rst_mem_wait", mem_wait, 0);
        chk("rst_fetch_err", fetch_err, 0);
        chk("rst_pc", pc, 0);
        exec = 1;
        tick();
        chk("t1_arvalid", arvalid, 1);
        chk("t1_araddr", araddr, 32'h0);
        chk("t1_arlen", arlen, 3);
        chk("t1_arsize", arsize, 3'b010);
        chk("t1_arburst", arburst, 2'b01);
        chk("t1_arcache", arcache, 4'b0011);
        chk("t1_mem_wait", mem_wait, 1);
        wait_sel("t1_inst_wait", 0);
        for (int i = 0; i < 4; i++) begin
            chk("t1_valid", inst_valid, 1);
            chk("t1_pc", pc, 32'(4 * i));
            chk("t1_inst", inst, mem_word(32'(4 * i)));
            tick();
        end
        wait_sel("t1_ar2_wait", 1);
        chk("t1_ar2_addr", araddr, 32'h10);
        chk("t1_ar2_len", arlen, 3);

        // 2: stalled FIFO fills, AR gated by free slots
        do_reset();
        exec = 1; stall = 1;
        repeat (30) tick();
        chk("t2_ar_count", ar_count, 2);
        chk("t2_arvalid", arvalid, 0);
        chk("t2_pc_hold", pc, 32'h0);
        chk("t2_inst", inst, mem_word(32'h0));
        chk("t2_valid", inst_valid, 1);
        stall = 0; tick(); stall = 1;
        chk("t2_pc_pop1", pc, 32'h4);
        repeat (5) tick();
        chk("t2_no_ar", ar_count, 2);
        chk("t2_no_arvalid", arvalid, 0);
        stall = 0; repeat (3) tick(); stall = 1;
        chk("t2_pc_pop4", pc, 32'h10);
        wait_sel("t2_ar3_wait", 1);
        chk("t2_ar3_addr", araddr, 32'h20);
        chk("t2_pc_still", pc, 32'h10);

        // 3: redirect during beat 2 drops remaining beats, partial burst to boundary
        do_reset();
        exec = 1;
        wait_sel("t3_beat2_wait", 2);
        redirect = 1; redirect_pc = 32'h106;
        tick();
        redirect = 0;
        chk("t3_pc", pc, 32'h104);
        chk("t3_flushed", inst_valid, 0);
        wait_sel("t3_ar_wait", 1);
        chk("t3_araddr", araddr, 32'h104);
        chk("t3_arlen", arlen, 2);
        wait_sel("t3_inst_wait", 0);
        for (int i = 0; i < 3; i++) begin
            chk("t3_pc_seq", pc, 32'h104 + 32'(4 * i));
            chk("t3_inst_seq", inst, mem_word(32'h104 + 32'(4 * i)));
            tick();
        end
        wait_sel("t3_ar2_wait", 1);
        chk("t3_ar2_addr", araddr, 32'h110);
        chk("t3_ar2_len", arlen, 3);

        // 4: redirect while AR stalled; AR held stable, whole burst discarded
        do_reset();
        ar_block = 1; exec = 1;
        tick();
        chk("t4_arvalid0", arvalid, 1);
        redirect = 1; redirect_pc = 32'h40;
        tick();
        redirect = 0;
        for (int i = 0; i < 5; i++) begin
            chk("t4_arvalid_hold", arvalid, 1);
            chk("t4_araddr_hold", araddr, 32'h0);
            chk("t4_arlen_hold", arlen, 3);
            tick();
        end
        chk("t4_pc", pc, 32'h40);
        ar_block = 0;
        tick();
        wait_sel("t4_ar_wait", 1);
        chk("t4_new_araddr", araddr, 32'h40);
        chk("t4_new_arlen", arlen, 3);
        wait_sel("t4_inst_wait", 0);
        chk("t4_first_pc", pc, 32'h40);
        chk("t4_first_inst", inst, mem_word(32'h40));

        // 5: error response is sticky, beat still delivered
        do_reset();
        err_addr = 32'h8; exec = 1;
        wait_sel("t5_inst_wait", 0);
        for (int i = 0; i < 4; i++) begin
            chk("t5_pc", pc, 32'(4 * i));
            chk("t5_inst", inst, mem_word(32'(4 * i)));
            chk("t5_err", fetch_err, i >= 2 ? 1 : 0);
            tick();
        end
        repeat (10) tick();
        chk("t5_err_sticky", fetch_err, 1);
        do_reset();
        err_addr = 32'h1;
        chk("t5_err_cleared", fetch_err, 0);

        // 6: reset mid-burst
        exec = 1;
        wait_sel("t6_inst_wait", 0);
        repeat (2) tick();
        chk("t6_in_data", rready, 1);
        chk("t6_pc_pre", pc, 32'h8);
        rst = 1;
        tick();
        chk("t6_arvalid", arvalid, 0);
        chk("t6_rready", rready, 0);
        chk("t6_inst_valid", inst_valid, 0);
        chk("t6_pc", pc, 32'h0);
        rst = 0; exec = 0;
        tick();

        // 7: redirect to top of memory, PC wraps to zero
        exec = 1; redirect = 1; redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect = 0;
        chk("t7_no_ar_yet", arvalid, 0);
        chk("t7_pc_aligned", pc, 32'hFFFF_FFFC);
        tick();
        chk("t7_arvalid", arvalid, 1);
        chk("t7_araddr", araddr, 32'hFFFF_FFFC);
        chk("t7_arlen", arlen, 0);
        wait_sel("t7_rvalid_wait", 3);
        chk("t7_lat_before", inst_valid, 0);
        tick();
        chk("t7_lat_after", inst_valid, 1);
        chk("t7_pc_top", pc, 32'hFFFF_FFFC);
        chk("t7_inst_top", inst, mem_word(32'hFFFF_FFFC));
        tick();
        chk("t7_pc_wrap", pc, 32'h0);
        wait_sel("t7_ar2_wait", 1);
        chk("t7_ar2_addr", araddr, 32'h0);
        chk("t7_ar2_len", arlen, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
